// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush sequencer.
//   state_e      : sequencer state {RUN, DIV_WAIT, DRAIN}
//   DIV_LAT_DEF  : default divide occupancy of EX, in cycles
//   STG_*        : stage indices used for the internal enable/clear vectors
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        DRAIN    = 2'd2
    } state_e;

    localparam int DIV_LAT_DEF = 34;

    localparam int STG_F = 0;   // PC
    localparam int STG_D = 1;   // IF/ID
    localparam int STG_E = 2;   // ID/EX
    localparam int STG_M = 3;   // EX/MEM
    localparam int STG_W = 4;   // MEM/WB

endpackage

// File: rtl/pipe_stall_ctrl_div_stall_cnt.sv
// div_stall_cnt: divide occupancy counter.
//   clk, rst  : core clock, asynchronous active-high reset
//   i_load    : load DIV_LAT-1 (divide issued)
//   i_dec     : decrement by one; ignored when already zero
//   i_abort   : clear to zero (divide killed by flush); beats i_load/i_dec
//   o_cnt     : current count
//   o_zero    : count is zero
//   o_one     : count is one (last busy cycle)
module div_stall_cnt #(
    parameter int DIV_LAT = 34,
    parameter int CW      = $clog2(DIV_LAT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_dec,
    input  logic          i_abort,
    output logic [CW-1:0] o_cnt,
    output logic          o_zero,
    output logic          o_one
);

    localparam logic [CW-1:0] LOAD_VAL = CW'(DIV_LAT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_abort)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= LOAD_VAL;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - CW'(1);
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);
    assign o_one  = (r_cnt == CW'(1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush sequencer for the 5-stage pipeline.
//   Inputs : clk, rst (async, active-high), inst_stall, data_stall, load_use,
//            div_start_e, flush_req_m
//   Outputs: en_f; en_d/clr_d, en_e/clr_e, en_m/clr_m, en_w/clr_w (clr wins);
//            div_busy, div_abort, redirect, fetch_discard
//   Optional (PIPE_CTRL_PERF_EN): perf_stall_cnt[31:0] (saturating count of
//            cycles with en_d=0 or clr_d=1), perf_flush_cnt[15:0] (wrapping
//            count of flush cycles).
// Outputs are combinational from registered state plus current inputs.
// Event priority: flush > data_stall > DRAIN > DIV_WAIT > load_use > inst_stall.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_stall,
    input  logic        data_stall,
    input  logic        load_use,
    input  logic        div_start_e,
    input  logic        flush_req_m,
    output logic        en_f,
    output logic        en_d,
    output logic        clr_d,
    output logic        en_e,
    output logic        clr_e,
    output logic        en_m,
    output logic        clr_m,
    output logic        en_w,
    output logic        clr_w,
    output logic        div_busy,
    output logic        div_abort,
    output logic        redirect,
    output logic        fetch_discard
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    localparam int CW = $clog2(DIV_LAT);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [STG_W:STG_F]  w_en;
    logic [STG_W:STG_D]  w_clr;
    logic                w_load;
    logic                w_dec;
    logic                w_abort;
    logic                w_redirect;
    logic [CW-1:0]       w_cnt;
    logic                w_cnt_zero;
    logic                w_cnt_one;

    div_stall_cnt #(
        .DIV_LAT (DIV_LAT),
        .CW      (CW)
    ) u_div_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_dec   (w_dec),
        .i_abort (w_abort),
        .o_cnt   (w_cnt),
        .o_zero  (w_cnt_zero),
        .o_one   (w_cnt_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_en        = '1;
        w_clr       = '0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_abort     = 1'b0;
        w_redirect  = 1'b0;
        // Held in reset, outputs stay at the pass-through defaults whatever the inputs.
        if (!rst) begin
            if (flush_req_m) begin
                // D-side cancels its own access on flush, so data_stall is moot here.
                w_clr      = '1;
                w_redirect = 1'b1;
                w_abort    = (r_state == DIV_WAIT);
                // A fetch still outstanding belongs to the flushed path.
                w_state_nxt = inst_stall ? DRAIN : RUN;
            end else if (data_stall) begin
                w_en[STG_F] = 1'b0;
                w_en[STG_D] = 1'b0;
                w_en[STG_E] = 1'b0;
                w_en[STG_M] = 1'b0;
                w_clr[STG_W] = 1'b1;
                // The stale I-side return is dropped regardless of the D-side freeze.
                if ((r_state == DRAIN) && !inst_stall)
                    w_state_nxt = RUN;
            end else if (r_state == DRAIN) begin
                w_en[STG_F]  = 1'b0;
                w_clr[STG_D] = 1'b1;
                if (!inst_stall)
                    w_state_nxt = RUN;
            end else if (r_state == DIV_WAIT) begin
                w_en[STG_F]  = 1'b0;
                w_en[STG_D]  = 1'b0;
                w_en[STG_E]  = 1'b0;
                w_clr[STG_M] = 1'b1;
                w_dec        = 1'b1;
                if (w_cnt_one || w_cnt_zero)
                    w_state_nxt = RUN;
            end else begin
                // The issuing cycle itself advances normally.
                if (div_start_e) begin
                    w_load      = 1'b1;
                    w_state_nxt = DIV_WAIT;
                end
                if (load_use) begin
                    w_en[STG_F]  = 1'b0;
                    w_en[STG_D]  = 1'b0;
                    w_clr[STG_E] = 1'b1;
                end else if (inst_stall) begin
                    w_en[STG_F]  = 1'b0;
                    w_clr[STG_D] = 1'b1;
                end
            end
        end
    end

    assign en_f          = w_en[STG_F];
    assign en_d          = w_en[STG_D];
    assign en_e          = w_en[STG_E];
    assign en_m          = w_en[STG_M];
    assign en_w          = w_en[STG_W];
    assign clr_d         = w_clr[STG_D];
    assign clr_e         = w_clr[STG_E];
    assign clr_m         = w_clr[STG_M];
    assign clr_w         = w_clr[STG_W];
    assign div_busy      = !rst && (r_state == DIV_WAIT);
    assign div_abort     = w_abort;
    assign redirect      = w_redirect;
    assign fetch_discard = !rst && (r_state == DRAIN);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [15:0] r_perf_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if ((!w_en[STG_D] || w_clr[STG_D]) && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
            if (flush_req_m)
                r_perf_flush <= r_perf_flush + 16'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed-vector bench for pipe_stall_ctrl (DIV_LAT=34).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic inst_stall, data_stall, load_use, div_start_e, flush_req_m;
    logic en_f, en_d, clr_d, en_e, clr_e, en_m, clr_m, en_w, clr_w;
    logic div_busy, div_abort, redirect, fetch_discard;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.DIV_LAT(34)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_stall    (inst_stall),
        .data_stall    (data_stall),
        .load_use      (load_use),
        .div_start_e   (div_start_e),
        .flush_req_m   (flush_req_m),
        .en_f          (en_f),
        .en_d          (en_d),
        .clr_d         (clr_d),
        .en_e          (en_e),
        .clr_e         (clr_e),
        .en_m          (en_m),
        .clr_m         (clr_m),
        .en_w          (en_w),
        .clr_w         (clr_w),
        .div_busy      (div_busy),
        .div_abort     (div_abort),
        .redirect      (redirect),
        .fetch_discard (fetch_discard)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    // {en_f,en_d,en_e,en_m,en_w}, {clr_d,clr_e,clr_m,clr_w}, {busy,abort,redirect,discard}
    wire [4:0] w_en  = {en_f, en_d, en_e, en_m, en_w};
    wire [3:0] w_clr = {clr_d, clr_e, clr_m, clr_w};
    wire [3:0] w_flg = {div_busy, div_abort, redirect, fetch_discard};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic drive(input logic is, input logic ds, input logic lu,
                         input logic dv, input logic fl);
        inst_stall  = is;
        data_stall  = ds;
        load_use    = lu;
        div_start_e = dv;
        flush_req_m = fl;
    endtask

    // Sample this cycle's outputs, then move to just after the next rising edge.
    task automatic look(input string tag, input logic [4:0] en, input logic [3:0] clr,
                        input logic [3:0] flg);
        @(negedge clk);
        chk({tag, ".en"},  32'(w_en),  32'(en));
        chk({tag, ".clr"}, 32'(w_clr), 32'(clr));
        chk({tag, ".flg"}, 32'(w_flg), 32'(flg));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        look("rst", 5'b11111, 4'b0000, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Idle and single hazards from RUN.
        look("idle", 5'b11111, 4'b0000, 4'b0000);
        drive(1, 0, 0, 0, 0); look("istall", 5'b01111, 4'b1000, 4'b0000);
        drive(1, 0, 1, 0, 0); look("lu_over_is", 5'b00111, 4'b0100, 4'b0000);

        // Test 1: full divide, 33 busy cycles then RUN.
        drive(0, 0, 0, 1, 0); look("div_issue", 5'b11111, 4'b0000, 4'b0000);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 33; i++) begin
            // div_start_e again mid-divide must be ignored.
            div_start_e = (i == 5);
            look($sformatf("div_busy%0d", i), 5'b00011, 4'b0010, 4'b1000);
        end
        drive(0, 0, 0, 0, 0); look("div_done", 5'b11111, 4'b0000, 4'b0000);

        // Divide stretched by data_stall: counter frozen for the stalled cycle.
        drive(0, 0, 0, 1, 0); look("div2_issue", 5'b11111, 4'b0000, 4'b0000);
        for (int i = 0; i < 34; i++) begin
            data_stall = (i == 3);
            if (i == 3) look("div2_ds", 5'b00001, 4'b0001, 4'b1000);
            else        look($sformatf("div2_busy%0d", i), 5'b00011, 4'b0010, 4'b1000);
        end
        drive(0, 0, 0, 0, 0); look("div2_done", 5'b11111, 4'b0000, 4'b0000);

        // Test 2: flush kills an in-flight divide.
        drive(0, 0, 0, 1, 0); look("div3_issue", 5'b11111, 4'b0000, 4'b0000);
        idle(9);
        drive(0, 0, 0, 0, 1); look("flush_div", 5'b11111, 4'b1111, 4'b1110);
        drive(0, 0, 0, 0, 0); look("post_abort", 5'b11111, 4'b0000, 4'b0000);

        // Test 3: flush with fetch outstanding, return arrives 3 cycles later.
        drive(1, 0, 0, 0, 1); look("flush_is", 5'b11111, 4'b1111, 4'b0010);
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            look($sformatf("drain%0d", i), 5'b01111, 4'b1000, 4'b0001);
        drive(0, 0, 0, 0, 0); look("drain_last", 5'b01111, 4'b1000, 4'b0001);
        look("drain_exit", 5'b11111, 4'b0000, 4'b0000);

        // Test 4: data_stall beats load_use; load_use honoured next cycle.
        drive(0, 1, 1, 0, 0); look("ds_lu", 5'b00001, 4'b0001, 4'b0000);
        drive(0, 0, 1, 0, 0); look("lu_after", 5'b00111, 4'b0100, 4'b0000);

        // Test 5: flush beats data_stall.
        drive(0, 1, 0, 0, 1); look("flush_ds", 5'b11111, 4'b1111, 4'b0010);
        drive(0, 0, 0, 0, 0); look("flush_ds_nx", 5'b11111, 4'b0000, 4'b0000);

`ifdef PIPE_CTRL_PERF_EN
        @(negedge clk);
        chk("perf_flush", 32'(perf_flush_cnt), 32'd3);
        @(posedge clk); #1;
`endif

        // Test 6: async reset mid-divide, with hazards still asserted.
        drive(0, 0, 0, 1, 0); look("div4_issue", 5'b11111, 4'b0000, 4'b0000);
        drive(1, 0, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async.en",  32'(w_en),  32'h1f);
        chk("rst_async.clr", 32'(w_clr), 32'h0);
        chk("rst_async.flg", 32'(w_flg), 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
        chk("rst_perf_flush", 32'(perf_flush_cnt), 32'd0);
`endif
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        look("rst_run", 5'b11111, 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
